// File: rtl/spiker_collector_if.sv
// spiker_collector_if: spike beat stream from the core plus the frame hand-off to the writer
interface spiker_collector_if #(
  parameter int WIDTH      = 32,
  parameter int DATA_WIDTH = 800
);
  logic [WIDTH-1:0]      spike_word_i;
  logic                  spike_valid_i;
  logic                  spike_last_i;
  logic                  spike_ready_o;
  logic [DATA_WIDTH-1:0] data_out_o;
  logic                  sample_o;
  logic                  writer_ready_i;
  modport master (
    output spike_word_i, spike_valid_i, spike_last_i, writer_ready_i,
    input  spike_ready_o, data_out_o, sample_o
  );
  modport slave (
    input  spike_word_i, spike_valid_i, spike_last_i, writer_ready_i,
    output spike_ready_o, data_out_o, sample_o
  );
endinterface

// File: rtl/spiker_collector.sv
// spiker_collector: packs WIDTH-bit spike beats into a double-buffered DATA_WIDTH frame; SPIKER_COLLECTOR_POPCOUNT_EN adds spike_total_o
module spiker_collector #(
  parameter int WIDTH      = 32,
  parameter int DATA_WIDTH = 800
) (
  input  logic        clk_i,
  input  logic        rst_i,
  spiker_collector_if.slave bus,
`ifdef SPIKER_COLLECTOR_POPCOUNT_EN
  output logic [$clog2(DATA_WIDTH+1)-1:0] spike_total_o,
`endif
  output logic [15:0] frame_cnt_o
);
  localparam int N_WORDS = (DATA_WIDTH + WIDTH - 1) / WIDTH;
  localparam int WI      = N_WORDS > 1 ? $clog2(N_WORDS) : 1;
  localparam logic [WIDTH-1:0] LAST_MASK = {WIDTH{1'b1}} >> (N_WORDS*WIDTH - DATA_WIDTH);
  typedef enum logic {FILL, PEND} state_t;
  state_t                   state;
  logic [WI-1:0]            widx;
  logic [N_WORDS*WIDTH-1:0] asm_q;
  logic                     accept, xfer, word_last, frame_done;
  logic [WIDTH-1:0]         beat;
  assign accept     = bus.spike_ready_o && bus.spike_valid_i;
  assign word_last  = widx == WI'(N_WORDS - 1);
  assign frame_done = bus.spike_last_i || word_last;
  assign beat       = bus.spike_word_i & (word_last ? LAST_MASK : {WIDTH{1'b1}});
  // sample_o guard absorbs a writer that drops ready one cycle after a strobe
  assign xfer       = state == PEND && bus.writer_ready_i && !bus.sample_o;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state             <= FILL;
      widx              <= '0;
      asm_q             <= '0;
      bus.data_out_o    <= '0;
      bus.sample_o      <= 1'b0;
      bus.spike_ready_o <= 1'b1;
      frame_cnt_o       <= '0;
    end else begin
      bus.sample_o <= xfer;
      if (accept) begin
        asm_q[widx*WIDTH +: WIDTH] <= beat;
        widx <= frame_done ? '0 : widx + 1'b1;
        if (frame_done) begin
          state             <= PEND;
          bus.spike_ready_o <= 1'b0;
        end
      end
      if (xfer) begin
        bus.data_out_o    <= asm_q[DATA_WIDTH-1:0];
        asm_q             <= '0;
        frame_cnt_o       <= frame_cnt_o + 16'd1;
        state             <= FILL;
        bus.spike_ready_o <= 1'b1;
      end
    end
  end
`ifdef SPIKER_COLLECTOR_POPCOUNT_EN
  localparam int CW = $clog2(DATA_WIDTH + 1);
  logic [CW-1:0] acc;
  // accepts only happen in FILL and transfers only in PEND, so they never collide
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc           <= '0;
      spike_total_o <= '0;
    end else if (xfer) begin
      acc           <= '0;
      spike_total_o <= acc;
    end else if (accept) begin
      acc <= acc + CW'($countones(beat));
    end
  end
`endif
endmodule

// File: tb/tb_spiker_collector.sv
// tb_spiker_collector: directed stimulus with a queue scoreboard checked by a sample_o monitor
module tb_spiker_collector;
  localparam int W  = 32;
  localparam int DW = 800;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  spiker_collector_if #(.WIDTH(W), .DATA_WIDTH(DW)) bus ();
  logic [15:0] frame_cnt;
`ifdef SPIKER_COLLECTOR_POPCOUNT_EN
  logic [9:0] spike_total;
  spiker_collector #(.WIDTH(W), .DATA_WIDTH(DW)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus), .spike_total_o(spike_total), .frame_cnt_o(frame_cnt));
`else
  spiker_collector #(.WIDTH(W), .DATA_WIDTH(DW)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus), .frame_cnt_o(frame_cnt));
`endif
  typedef struct {
    logic [DW-1:0] data;
    logic [15:0]   cnt;
    int            total;
  } exp_t;
  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] d, input logic [15:0] c, input int t);
    exp_t e;
    e.data = d; e.cnt = c; e.total = t;
    q.push_back(e);
  endtask

  task automatic beat(input logic [W-1:0] w, input logic last);
    int n = 0;
    @(negedge clk);
    bus.spike_word_i  = w;
    bus.spike_valid_i = 1'b1;
    bus.spike_last_i  = last;
    while (!bus.spike_ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_chk++; n_fail++;
      $display("FAIL beat_accept: ready never seen within %0d cycles", n);
    end
    @(posedge clk);
    #1 bus.spike_valid_i = 1'b0;
    bus.spike_last_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d frames still expected, required 0", q.size());
    end
  endtask

  initial begin : monitor
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) prev = 1'b0;
      else begin
        if (bus.sample_o) begin
          chk("sample_adjacent", DW'(prev), DW'(0));
          if (q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_sample: got sample_o=1 required no frame");
          end else begin
            e = q.pop_front();
            chk("frame_data", bus.data_out_o, e.data);
            chk("frame_cnt", DW'(frame_cnt), DW'(e.cnt));
`ifdef SPIKER_COLLECTOR_POPCOUNT_EN
            chk("spike_total", DW'(spike_total), DW'(e.total));
`endif
          end
        end
        prev = bus.sample_o;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] fb;
    bus.spike_word_i = '0; bus.spike_valid_i = 0; bus.spike_last_i = 0; bus.writer_ready_i = 1;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", DW'(bus.spike_ready_o), DW'(1));
    chk("rst_sample", DW'(bus.sample_o), DW'(0));
    chk("rst_data", bus.data_out_o, '0);
    chk("rst_cnt", DW'(frame_cnt), DW'(0));
    // T1 full frame, widx limit ends the frame
    push({DW{1'b1}}, 16'd1, 800);
    for (int i = 0; i < 25; i++) beat(32'hFFFF_FFFF, 1'b0);
    drain();
    // T2 early last
    push({704'b0, 96'h00000004_00000002_00000001}, 16'd2, 3);
    beat(32'h1, 1'b0); beat(32'h2, 1'b0); beat(32'h4, 1'b1);
    drain();
    // T3 back-pressure
    @(negedge clk) bus.writer_ready_i = 1'b0;
    push({25{32'h5A5A_C3C3}}, 16'd3, 400);
    for (int i = 0; i < 25; i++) beat(32'h5A5A_C3C3, i == 24);
    repeat (5) begin
      @(negedge clk);
      chk("bp_ready", DW'(bus.spike_ready_o), DW'(0));
      chk("bp_sample", DW'(bus.sample_o), DW'(0));
    end
    bus.writer_ready_i = 1'b1;
    @(negedge clk);
    chk("bp_latency", DW'(bus.sample_o), DW'(1));
    drain();
    // T4 back-to-back frames with the writer dropping ready after each strobe
    fb = '0;
    for (int i = 0; i < 25; i++) fb[i*W +: W] = 32'h1000_0000 | W'(i);
    push({25{32'h0000_FFFF}}, 16'd4, 400);
    push(fb, 16'd5, 79);
    fork
      repeat (80) begin
        @(negedge clk);
        bus.writer_ready_i = !bus.sample_o;
      end
      begin
        for (int i = 0; i < 25; i++) beat(32'h0000_FFFF, 1'b0);
        for (int i = 0; i < 25; i++) beat(32'h1000_0000 | W'(i), 1'b0);
      end
    join
    bus.writer_ready_i = 1'b1;
    drain();
    chk("b2b_cnt", DW'(frame_cnt), DW'(5));
    // single-beat frames at full rate
    push({768'b0, 32'h1}, 16'd6, 1);
    push({768'b0, 32'h3}, 16'd7, 2);
    push({768'b0, 32'h7}, 16'd8, 3);
    beat(32'h1, 1'b1); beat(32'h3, 1'b1); beat(32'h7, 1'b1);
    drain();
    // T5 reset mid-frame
    for (int i = 0; i < 10; i++) beat(32'hFFFF_FFFF, 1'b0);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_data", bus.data_out_o, '0);
    chk("mid_rst_cnt", DW'(frame_cnt), DW'(0));
    chk("mid_rst_sample", DW'(bus.sample_o), DW'(0));
    chk("mid_rst_ready", DW'(bus.spike_ready_o), DW'(1));
`ifdef SPIKER_COLLECTOR_POPCOUNT_EN
    chk("mid_rst_total", DW'(spike_total), DW'(0));
`endif
    push({736'b0, 32'h1234_5678, 32'hAAAA_5555}, 16'd1, 29);
    beat(32'hAAAA_5555, 1'b0); beat(32'h1234_5678, 1'b1);
    drain();
    // T6 popcount pattern
    push({25{32'hF0F0_F0F0}}, 16'd2, 400);
    for (int i = 0; i < 25; i++) beat(32'hF0F0_F0F0, 1'b0);
    drain();
    chk("final_cnt", DW'(frame_cnt), DW'(2));
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
